// File: rtl/fp_add_operand_feeder.sv
// -----------------------------------------------------------------------------
// fp_add_operand_feeder
//
// Front end of the single-precision adder. Operand pairs arrive over a
// valid/ready handshake, are buffered raw in a small FIFO, and are handed to
// the adder one registered pair at a time. The registered pair is ordered so
// the larger magnitude comes first, and each operand carries a class flag
// (NaN / Inf / zero / denormal).
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   source presents a pair
//   in_ready   feeder has room (FIFO not full)
//   in_a/in_b  raw IEEE-754 single-precision operands
//   out_ready  adder accepts the current pair
//   out_valid  out_* holds a valid pair
//   out_a      larger-magnitude operand
//   out_b      smaller-magnitude operand
//   out_swap   1 when in_a/in_b were exchanged
//   out_flags  {a_nan, a_inf, a_zero, a_denorm, b_nan, b_inf, b_zero, b_denorm}
//   level      FIFO occupancy (output register not counted)
// -----------------------------------------------------------------------------
module fp_add_operand_feeder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [31:0]   out_a,
    output logic [31:0]   out_b,
    output logic          out_swap,
    output logic [7:0]    out_flags,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    // FIFO storage holds the raw {a, b} pair; ordering and classification are
    // done on the way out so the RAM stays a plain 64-bit memory.
    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    logic          r_out_valid;
    logic [31:0]   r_out_a;
    logic [31:0]   r_out_b;
    logic          r_out_swap;
    logic [7:0]    r_out_flags;

    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_head;
    logic [31:0]   w_head_a;
    logic [31:0]   w_head_b;
    logic          w_swap;
    logic [31:0]   w_ord [2];
    logic [3:0]    w_class [2];

    // Full-ness alone gates acceptance: a pop in the same cycle does not free
    // a slot for a same-cycle push, which keeps in_ready off the out_ready path.
    assign in_ready = (r_level != FULL_LEVEL);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_level != '0) && (!r_out_valid || out_ready);

    assign w_head   = r_mem[r_rd_ptr];
    assign w_head_a = w_head[63:32];
    assign w_head_b = w_head[31:0];

    // Magnitude compare ignores the sign bit; ties keep the original order.
    assign w_swap   = (w_head_b[30:0] > w_head_a[30:0]);
    assign w_ord[0] = w_swap ? w_head_b : w_head_a;
    assign w_ord[1] = w_swap ? w_head_a : w_head_b;

    // Per-operand class: {nan, inf, zero, denorm}, sign ignored.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_class
            logic w_exp_max;
            logic w_exp_min;
            logic w_mant_nz;
            assign w_exp_max   = (w_ord[gi][30:23] == 8'hFF);
            assign w_exp_min   = (w_ord[gi][30:23] == 8'h00);
            assign w_mant_nz   = (w_ord[gi][22:0] != 23'd0);
            assign w_class[gi] = {w_exp_max &&  w_mant_nz,
                                  w_exp_max && !w_mant_nz,
                                  w_exp_min && !w_mant_nz,
                                  w_exp_min &&  w_mant_nz};
        end
    endgenerate

    // Memory array is not reset; its contents are only meaningful under level.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_swap  <= 1'b0;
            r_out_flags <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_a     <= w_ord[0];
            r_out_b     <= w_ord[1];
            r_out_swap  <= w_swap;
            r_out_flags <= {w_class[0], w_class[1]};
        end else if (r_out_valid && out_ready) begin
            // Consumed with nothing behind it: the register goes empty but
            // keeps its last data (only out_valid matters to the adder).
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_swap  = r_out_swap;
    assign out_flags = r_out_flags;
    assign level     = r_level;

endmodule

// File: tb/tb_fp_add_operand_feeder.sv
module tb_fp_add_operand_feeder;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_swap;
    logic [7:0]  out_flags;
    logic [2:0]  level;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected {out_a, out_b, out_swap, out_flags}
    logic [72:0] exp_q[$];

    fp_add_operand_feeder #(.DEPTH(4), .AW(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_swap  (out_swap),
        .out_flags (out_flags),
        .level     (level)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] cls(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[30:23];
        m = v[22:0];
        if (e == 8'hFF) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 8'h00) return (m != 0) ? 4'b0001 : 4'b0010;
        return 4'b0000;
    endfunction

    function automatic logic [72:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi, lo;
        logic        sw;
        sw = ({1'b0, b[30:0]} > {1'b0, a[30:0]});
        hi = sw ? b : a;
        lo = sw ? a : b;
        return {hi, lo, sw, cls(hi), cls(lo)};
    endfunction

    // Scoreboard: every transfer on the output side is checked against the
    // oldest expected pair. Inputs change at posedge+1, so negedge is stable.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got a=%08h b=%08h, expected no output", out_a, out_b);
            end else begin
                logic [72:0] e;
                e = exp_q.pop_front();
                if ({out_a, out_b, out_swap, out_flags} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_pair: got a=%08h b=%08h sw=%0b fl=%02h, expected a=%08h b=%08h sw=%0b fl=%02h",
                             out_a, out_b, out_swap, out_flags, e[72:41], e[40:9], e[8], e[7:0]);
                end else begin
                    $display("xfer a=%08h b=%08h sw=%0b fl=%02h ok", out_a, out_b, out_swap, out_flags);
                end
            end
        end
    end

    // Presents one pair and returns #1 after the edge that accepted it.
    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        int waited;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        waited   = 0;
        @(negedge clock);
        while (!in_ready && waited < 30) begin
            waited++;
            @(negedge clock);
        end
        if (!in_ready) begin
            n_assert++;
            n_fail++;
            $display("FAIL push_timeout: in_ready=%0b, expected 1 within 30 cycles", in_ready);
        end else begin
            exp_q.push_back(model(a, b));
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) @(posedge clock);
        #1;
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_empty: %0d pairs outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_assert++;
        if ({out_valid, out_a, out_b, out_swap, out_flags, level, in_ready} !== {1'b0, 73'd0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: ov=%0b a=%08h b=%08h sw=%0b fl=%02h lvl=%0d rdy=%0b, expected all zero with rdy=1",
                     out_valid, out_a, out_b, out_swap, out_flags, level, in_ready);
        end
        $display("reset checked");
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        push_pair(32'h49228521, 32'hC529AA28);
        n_assert++;
        if (out_valid !== 1'b0 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL latency_early: ov=%0b lvl=%0d, expected ov=0 lvl=1", out_valid, level);
        end
        @(posedge clock); #1;
        n_assert++;
        if ({out_valid, out_a, out_b, out_swap, out_flags} !== {1'b1, 32'h49228521, 32'hC529AA28, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL basic_pair: ov=%0b a=%08h b=%08h sw=%0b fl=%02h, expected 1 49228521 c529aa28 0 00",
                     out_valid, out_a, out_b, out_swap, out_flags);
        end
        push_pair(32'hC529AA28, 32'h49228521);
        @(posedge clock); #1;
        n_assert++;
        if ({out_a, out_b, out_swap} !== {32'h49228521, 32'hC529AA28, 1'b1}) begin
            n_fail++;
            $display("FAIL swap_pair: a=%08h b=%08h sw=%0b, expected 49228521 c529aa28 1", out_a, out_b, out_swap);
        end
        push_pair(32'h3F800000, 32'hBF800000);
        @(posedge clock); #1;
        n_assert++;
        if ({out_a, out_b, out_swap} !== {32'h3F800000, 32'hBF800000, 1'b0}) begin
            n_fail++;
            $display("FAIL tie_pair: a=%08h b=%08h sw=%0b, expected 3f800000 bf800000 0", out_a, out_b, out_swap);
        end
        drain(3);
    endtask

    task automatic test_backpressure;
        logic [2:0] exp_lvl;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_pair(32'h40000000 + 32'(i), 32'h3F000000 + 32'(i * 3));
        n_assert++;
        if (level !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 32'h40000000) begin
            n_fail++;
            $display("FAIL full_state: lvl=%0d rdy=%0b ov=%0b a=%08h, expected 4 0 1 40000000", level, in_ready, out_valid, out_a);
        end
        // Sixth pair offered while full must be refused.
        in_valid = 1'b1; in_a = 32'h12345678; in_b = 32'h00000000;
        repeat (3) @(posedge clock);
        #1;
        in_valid = 1'b0;
        n_assert++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_refuse: lvl=%0d rdy=%0b, expected 4 0", level, in_ready);
        end
        out_ready = 1'b1;
        exp_lvl = 3'd4;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            exp_lvl = exp_lvl - 3'd1;
            n_assert++;
            if (level !== exp_lvl || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_level: lvl=%0d ov=%0b, expected %0d 1", level, out_valid, exp_lvl);
            end
        end
        @(posedge clock); #1;
        n_assert++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty_valid: ov=%0b, expected 0", out_valid);
        end
        drain(1);
    endtask

    task automatic test_specials;
        logic [31:0] sa [3];
        logic [31:0] sb [3];
        logic [7:0]  sf [3];
        sa[0] = 32'h7FC00000; sb[0] = 32'h00000001; sf[0] = 8'h81;
        sa[1] = 32'h7F800000; sb[1] = 32'h80000000; sf[1] = 8'h42;
        sa[2] = 32'h00000000; sb[2] = 32'h00000000; sf[2] = 8'h22;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_pair(sa[i], sb[i]);
            @(posedge clock); #1;
            n_assert++;
            if (out_flags !== sf[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL special_flags%0d: fl=%02h ov=%0b, expected %02h 1", i, out_flags, out_valid, sf[i]);
            end
        end
        drain(2);
    endtask

    task automatic test_back_to_back;
        int bad_lvl, bad_ov, bad_rdy;
        bad_lvl = 0; bad_ov = 0; bad_rdy = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_a = $urandom;
            in_b = $urandom;
            @(negedge clock);
            if (level > 3'd1) bad_lvl++;
            if (i >= 2 && out_valid !== 1'b1) bad_ov++;
            if (in_ready !== 1'b1) bad_rdy++;
            else exp_q.push_back(model(in_a, in_b));
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(negedge clock);
        if (out_valid !== 1'b1) bad_ov++;
        n_assert++;
        if (bad_lvl != 0 || bad_ov != 0 || bad_rdy != 0) begin
            n_fail++;
            $display("FAIL stream_flow: level>1 %0d times, out_valid gaps %0d, in_ready low %0d, expected 0 0 0", bad_lvl, bad_ov, bad_rdy);
        end
        drain(3);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_pair(32'h41000000 + 32'(i), 32'h40800000);
        n_assert++;
        if (level !== 3'd3 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: lvl=%0d ov=%0b, expected 3 1", level, out_valid);
        end
        #2 reset = 1'b1;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || out_a !== 32'd0 || out_b !== 32'd0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: ov=%0b a=%08h b=%08h lvl=%0d, expected 0 0 0 0", out_valid, out_a, out_b, level);
        end
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
            n_assert++;
            if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset: ov=%0b lvl=%0d rdy=%0b, expected 0 0 1", out_valid, level, in_ready);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_specials;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_add_operand_feeder.md
Name: fp_add_operand_feeder

Overview:
Upstream stage of the single-precision IEEE-754 adder. It accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. It presents one registered pair per accepted transfer to the adder inputs, with the larger-magnitude operand first, plus per-operand special-value flags. This decouples bursty operand sources from the adder's one-pair-per-clock input.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
AW, 2, FIFO pointer width; log2(DEPTH)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  source presents a pair
in_ready  output  1  feeder can accept a pair
in_a  input  32  operand A (sign[31], exp[30:23], mant[22:0])
in_b  input  32  operand B
out_ready  input  1  adder side accepts the current pair
out_valid  output  1  out_* holds a valid pair
out_a  output  32  larger-magnitude operand
out_b  output  32  smaller-magnitude operand
out_swap  output  1  1 if in_a/in_b were exchanged
out_flags  output  8  [7]a_nan [6]a_inf [5]a_zero [4]a_denorm [3:0] same order for out_b
level  output  AW+1  FIFO occupancy, 0..DEPTH, excluding the output register

Behaviour:
- Reset, asynchronous, any cycle: FIFO pointers = 0, level = 0, out_valid = 0, out_a = out_b = 0, out_swap = 0, out_flags = 0. in_ready = 1 after release. A pair in flight mid-operation is discarded; there is no partial state.
- Accept: a pair is written when in_valid && in_ready at a rising edge.
- in_ready = (level != DEPTH). It depends only on occupancy, not on out_ready. When full, a simultaneous pop does not allow a same-cycle push.
- Storage: FIFO holds raw {in_a, in_b} (64 bits). Write pointer and read pointer wrap modulo DEPTH.
- Output register load: at an edge where level != 0 and (!out_valid || out_ready), pop the head into the output register and set out_valid = 1.
- Output register drain: at an edge where out_valid && out_ready and level == 0, set out_valid = 0.
- out_* hold stable while out_valid && !out_ready.
- Latency: a pair accepted at edge N with an empty FIFO and an empty or draining output register shows out_valid = 1 after edge N+1.
- Throughput: one pair per clock when both sides stream continuously.
- Level update: push only → +1; pop only → -1; push and pop together → unchanged.
- Swap rule: compare magA = A[30:0] against magB = B[30:0] as unsigned values. If magB > magA, then out_a = B, out_b = A, out_swap = 1. Otherwise there is no swap (ties and equal magnitudes keep the original order).
- Flags are computed on the post-swap operands:
  - nan = exp == 8'hFF and mant != 0
  - inf = exp == 8'hFF and mant == 0
  - zero = exp == 0 and mant == 0
  - denorm = exp == 0 and mant != 0
  - Sign is ignored for all flags. At most one flag per operand is set.
- NaN payloads and signs pass through unmodified. No arithmetic is performed.

Test Plan:
- Reset, then push A=0x49228521, B=0xC529AA28 with out_ready=1 → one cycle after accept: out_valid=1, out_a=0x49228521, out_b=0xC529AA28, out_swap=0, out_flags=0x00.
- Push A=0xC529AA28, B=0x49228521 → out_a=0x49228521, out_b=0xC529AA28, out_swap=1. Push A=0x3F800000, B=0xBF800000 (equal magnitude) → out_swap=0.
- Hold out_ready=0 and push 5 distinct pairs → first pair in the output register, level=4, in_ready=0 after the 5th accept, and a 6th pair is not accepted. Then raise out_ready → pairs emerge in order, one per clock, and level decrements to 0.
- Specials: A=0x7FC00000, B=0x00000001 → out_flags=0x81. A=0x7F800000, B=0x80000000 → out_flags=0x42. A=0x00000000, B=0x00000000 → out_flags=0x22.
- Continuous stream of 16 pairs with in_valid=1 and out_ready=1 → level stays at most 1, out_valid is continuously 1 after the first output, and the output order matches input order across pointer wrap.
- Assert reset while level=3 and out_valid=1 → outputs clear immediately (asynchronously). After release, level=0, in_ready=1, and no stale pair appears.
